// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one word read in flight to
// instruction memory and buffers returned words with their PCs for the decode stage.
module fetch_unit #(
   parameter int                   BIT_WIDTH  = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_PC   = '0,
   parameter int                   FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [BIT_WIDTH-1:0] imem_req_addr,
   input  logic                 imem_resp_valid,
   input  logic [BIT_WIDTH-1:0] imem_resp_data,
   input  logic                 branch_valid,
   input  logic [BIT_WIDTH-1:0] branch_target,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [BIT_WIDTH-1:0] inst_data,
   output logic [BIT_WIDTH-1:0] inst_pc
);

   localparam int                   PTR_W      = $clog2(FIFO_DEPTH);
   localparam int                   CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_WIDTH-1:0] PC_STEP    = BIT_WIDTH'(4);
   localparam logic [BIT_WIDTH-1:0] ALIGN_MASK = ~BIT_WIDTH'(3);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_SQUASH
   } state_t;

   state_t               state;
   logic [BIT_WIDTH-1:0] pc;
   logic [BIT_WIDTH-1:0] pc_inflight;

   logic [BIT_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
   logic [BIT_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;

   logic fifo_has_room;
   logic req_fire;
   logic push;
   logic pop;

   // Outputs depend on branch_valid in the same cycle, so they are decoded from the
   // registered state rather than registered themselves; reset forces them all to 0.
   assign fifo_has_room  = (count < DEPTH_C);
   assign imem_req_valid = !reset && (state == S_REQ) && fifo_has_room && !branch_valid;
   assign imem_req_addr  = reset ? '0 : pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid = !reset && (count != '0);
   assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

   // A redirect discards both the incoming word and the decode-side pop.
   assign push = (state == S_WAIT) && imem_resp_valid && !branch_valid;
   assign pop  = inst_valid && inst_ready && !branch_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         pc_inflight <= '0;
      end else begin
         if (branch_valid) begin
            pc <= branch_target & ALIGN_MASK;
         end else if (req_fire) begin
            pc <= pc + PC_STEP;
         end
         if (req_fire) begin
            pc_inflight <= pc;
         end
         case (state)
            S_REQ: begin
               if (req_fire) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp_valid)   state <= S_REQ;
               else if (branch_valid) state <= S_SQUASH;
            end
            S_SQUASH: begin
               if (imem_resp_valid) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (branch_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // NOTE: buffer storage has no reset; count alone says which entries are live,
   // and the output mux hides stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= pc_inflight;
         fifo_data[wr_ptr] <= imem_resp_data;
      end
   end

   a_push_has_room: assert property (@(posedge clk) disable iff (reset) push |-> fifo_has_room);
   a_addr_aligned:  assert property (@(posedge clk) disable iff (reset) imem_req_addr[1:0] == 2'b00);

endmodule
